regfile_wb_arbiter: RTL and testbench

- Write-side companion of the 32 x 32b RISC-V register file.
- Merges two result sources onto the file's single write port (Write_reg / Write_data / WEN): the in-order pipeline writeback and a long-latency unit (load / mul-div).
- Long-latency results are buffered in a small FIFO behind a valid/ready handshake.
- Keeps a 32-bit busy scoreboard of destination registers with outstanding long-latency writes, so decode can stall on RAW/WAW hazards.

---
 rtl/regfile_wb_arbiter_if.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-side bus of the register file arbiter: pipeline writeback,
// long-latency result handshake, issue tracking and the file's write port.
interface regfile_wb_arbiter_if;
  logic        pipe_wen;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        stall_req;
  logic [31:0] busy;
  logic        WEN;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;

  modport master (
    output pipe_wen, pipe_rd, pipe_data,
    output lu_valid, lu_rd, lu_data,
    input  lu_ready,
    output issue_valid, issue_rd,
    input  stall_req, busy,
    input  WEN, Write_reg, Write_data
  );

  modport slave (
    input  pipe_wen, pipe_rd, pipe_data,
    input  lu_valid, lu_rd, lu_data,
    output lu_ready,
    input  issue_valid, issue_rd,
    output stall_req, busy,
    output WEN, Write_reg, Write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline writeback and buffered long-latency results onto the
// single register file write port, with starvation protection for the
// buffered results and a busy scoreboard of outstanding destinations.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                Clk,
  input logic                rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_LIMIT);

  logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
  logic [4:0]       fifo_rd_d   [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [31:0]      fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ST_W-1:0]  starve_q, starve_d;
  logic [31:0]      busy_q, busy_d;
  logic             wen_q, wen_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [31:0]      write_data_q, write_data_d;

  logic        fifo_empty;
  logic        lu_ready_w;
  logic        stall_w;
  logic        push;
  logic        pipe_ok;
  logic        pop;
  logic        pipe_win;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign fifo_empty = (count_q == '0);
  assign lu_ready_w = (count_q != FULL_CNT);
  assign stall_w    = (starve_q == ST_MAX) && !fifo_empty;
  assign push       = bus.lu_valid && lu_ready_w && (bus.lu_rd != 5'd0);
  assign pipe_ok    = bus.pipe_wen && (bus.pipe_rd != 5'd0);
  assign head_rd    = fifo_rd_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  assign bus.lu_ready   = lu_ready_w;
  assign bus.stall_req  = stall_w;
  assign bus.busy       = busy_q;
  assign bus.WEN        = wen_q;
  assign bus.Write_reg  = write_reg_q;
  assign bus.Write_data = write_data_q;

  // Pick the writer: a starved FIFO head first, then the pipeline, then the FIFO.
  always_comb begin
    pop      = 1'b0;
    pipe_win = 1'b0;
    if (stall_w) begin
      pop = 1'b1;
    end else if (pipe_ok) begin
      pipe_win = 1'b1;
    end else if (!fifo_empty) begin
      pop = 1'b1;
    end
  end

  // Next-state for the FIFO, starve counter, scoreboard and write port.
  always_comb begin
    fifo_rd_d    = fifo_rd_q;
    fifo_data_d  = fifo_data_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    starve_d     = starve_q;
    busy_d       = busy_q;
    wen_d        = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    if (push) begin
      fifo_rd_d[wr_ptr_q]   = bus.lu_rd;
      fifo_data_d[wr_ptr_q] = bus.lu_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (pop) begin
      wen_d        = 1'b1;
      write_reg_d  = head_rd;
      write_data_d = head_data;
    end else if (pipe_win) begin
      wen_d        = 1'b1;
      write_reg_d  = bus.pipe_rd;
      write_data_d = bus.pipe_data;
    end

    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (pipe_win && (starve_q != ST_MAX)) begin
      starve_d = starve_q + ST_W'(1);
    end

    if (pop) begin
      busy_d[head_rd] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops buffered results and busy bits at once.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      fifo_rd_q    <= '{default: '0};
      fifo_data_q  <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      busy_q       <= '0;
      wen_q        <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      fifo_rd_q    <= fifo_rd_d;
      fifo_data_q  <= fifo_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      busy_q       <= busy_d;
      wen_q        <= wen_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a queue-based model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(
    .FIFO_DEPTH  (DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .Clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [36:0] m_q[$];
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_wen;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  typedef struct {
    logic        pw;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        iv;
    logic [4:0]  ird;
    logic        e_wen;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [31:0] e_busy;
    logic        e_ready;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic pw, input logic [4:0] prd, input logic [31:0] pdata,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                input logic iv, input logic [4:0] ird);
    bus.pipe_wen    = pw;
    bus.pipe_rd     = prd;
    bus.pipe_data   = pdata;
    bus.lu_valid    = lv;
    bus.lu_rd       = lrd;
    bus.lu_data     = ldata;
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_busy   = '0;
    m_wen    = 1'b0;
  endtask

  // One clock with the currently driven inputs, checked against the model.
  task automatic model_cycle();
    logic        exp_ready, exp_stall, pipe_ok, was_empty, do_pop, pipe_win;
    logic [36:0] head;
    exp_ready = (m_q.size() != DEPTH);
    exp_stall = (m_starve == LIMIT) && (m_q.size() != 0);
    check_output("lu_ready", bus.lu_ready, exp_ready);
    check_output("stall_req", bus.stall_req, exp_stall);
    pipe_ok   = bus.pipe_wen && (bus.pipe_rd != 0);
    was_empty = (m_q.size() == 0);
    do_pop    = exp_stall || (!pipe_ok && !was_empty);
    pipe_win  = !exp_stall && pipe_ok;
    m_wen     = 1'b0;
    if (do_pop) begin
      head   = m_q.pop_front();
      m_wen  = 1'b1;
      m_reg  = head[36:32];
      m_data = head[31:0];
      m_busy[m_reg] = 1'b0;
    end else if (pipe_win) begin
      m_wen  = 1'b1;
      m_reg  = bus.pipe_rd;
      m_data = bus.pipe_data;
    end
    if (bus.lu_valid && exp_ready && bus.lu_rd != 0)
      m_q.push_back({bus.lu_rd, bus.lu_data});
    if (bus.issue_valid && bus.issue_rd != 0)
      m_busy[bus.issue_rd] = 1'b1;
    if (do_pop || was_empty)
      m_starve = 0;
    else if (pipe_win && m_starve < LIMIT)
      m_starve++;
    @(posedge clk);
    #1;
    check_output("WEN", bus.WEN, m_wen);
    if (m_wen) begin
      check_output("Write_reg", bus.Write_reg, m_reg);
      check_output("Write_data", bus.Write_data, m_data);
    end
    check_output("busy", bus.busy, m_busy);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 1'b1};
    vecs[1] = '{1'b1, 5'd0, 32'h0000AAAA, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                1'b0, 5'd0, 32'h0, 32'h0, 1'b1};
    vecs[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                1'b0, 5'd0, 32'h0, 32'h0000_0080, 1'b1};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0,
                1'b0, 5'd0, 32'h0, 32'h0000_0080, 1'b1};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                1'b1, 5'd7, 32'h12345678, 32'h0, 1'b1};
    vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                1'b0, 5'd0, 32'h0, 32'h0, 1'b1};
    vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000FFFF, 1'b0, 5'd0,
                1'b0, 5'd0, 32'h0, 32'h0, 1'b1};
    vecs[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                1'b0, 5'd0, 32'h0, 32'h0, 1'b1};
    vecs[8] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9,
                1'b0, 5'd0, 32'h0, 32'h0000_0200, 1'b1};
    vecs[9] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9,
                1'b1, 5'd9, 32'h00000099, 32'h0000_0200, 1'b1};

    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_output("rst_WEN", bus.WEN, 1'b0);
    check_output("rst_Write_reg", bus.Write_reg, 5'd0);
    check_output("rst_Write_data", bus.Write_data, 32'h0);
    check_output("rst_busy", bus.busy, 32'h0);
    check_output("rst_lu_ready", bus.lu_ready, 1'b1);
    check_output("rst_stall_req", bus.stall_req, 1'b0);
    reset_dut();

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].pw, vecs[i].prd, vecs[i].pdata, vecs[i].lv, vecs[i].lrd,
                     vecs[i].ldata, vecs[i].iv, vecs[i].ird);
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d_WEN", i), bus.WEN, vecs[i].e_wen);
      if (vecs[i].e_wen) begin
        check_output($sformatf("vec%0d_reg", i), bus.Write_reg, vecs[i].e_reg);
        check_output($sformatf("vec%0d_data", i), bus.Write_data, vecs[i].e_data);
      end
      check_output($sformatf("vec%0d_busy", i), bus.busy, vecs[i].e_busy);
      check_output($sformatf("vec%0d_ready", i), bus.lu_ready, vecs[i].e_ready);
    end

    // Full FIFO while the pipeline keeps winning.
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 5'd3, 32'h3333_0000 + k, 1, 5'(10 + k), 32'hA000_0000 + k, 1, 5'(10 + k));
      model_cycle();
    end
    apply_stimulus(1, 5'd3, 32'h3333_0004, 1, 5'd14, 32'hA000_0004, 0, 0);
    check_output("full_lu_ready", bus.lu_ready, 1'b0);
    model_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) model_cycle();
    check_output("drained_lu_ready", bus.lu_ready, 1'b1);

    // Starvation: one buffered entry against a continuous pipeline.
    reset_dut();
    apply_stimulus(1, 5'd4, 32'h0000_4444, 1, 5'd20, 32'h0000_2020, 0, 0);
    model_cycle();
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(1, 5'd4, 32'h0000_4444, 0, 0, 0, 0, 0);
      check_output($sformatf("starve_stall_k%0d", k), bus.stall_req, (k == 9));
      model_cycle();
      if (k == 9) begin
        check_output("starve_pop_reg", bus.Write_reg, 5'd20);
      end
      if (k == 10) begin
        check_output("starve_pipe_reg", bus.Write_reg, 5'd4);
      end
    end

    // Reset with two entries buffered.
    reset_dut();
    apply_stimulus(1, 5'd3, 32'h3, 1, 5'd21, 32'h21, 1, 5'd21);
    model_cycle();
    apply_stimulus(1, 5'd3, 32'h3, 1, 5'd22, 32'h22, 1, 5'd22);
    model_cycle();
    apply_stimulus(1, 5'd3, 32'h3, 0, 0, 0, 0, 0);
    model_cycle();
    #2;
    rst = 1'b1;
    #1;
    check_output("midrst_WEN", bus.WEN, 1'b0);
    check_output("midrst_busy", bus.busy, 32'h0);
    check_output("midrst_lu_ready", bus.lu_ready, 1'b1);
    check_output("midrst_stall_req", bus.stall_req, 1'b0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) model_cycle();

    // Random traffic against the model.
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      apply_stimulus($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
                     $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                     $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)));
      model_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
